// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scan with row sync, press/release debounce and one-hot key capture.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] keypad_val,
    output logic       key_valid
);
    localparam int CMAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t        state, state_nx;
    logic [3:0]    r_meta, rs, rlow, cand, cand_nx;
    logic [1:0]    col, col_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    val_nx;
    logic          valid_nx, rep_fire, one_hot, held_row;

    assign rlow     = ~rs;
    assign one_hot  = (rlow != 4'd0) && ((rlow & (rlow - 4'd1)) == 4'd0);
    assign held_row = |(rlow & cand);
    assign cols     = ~(4'b0001 << col);

    // The column index only moves in SCAN or when a debounce gives up, so it freezes on the pressed key.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        col_nx   = col;
        cand_nx  = cand;
        val_nx   = keypad_val;
        valid_nx = 1'b0;
        case (state)
            SCAN:
                if (cnt == SCAN_LAST) begin
                    cnt_nx = '0;
                    if (one_hot) begin
                        cand_nx  = rlow;
                        state_nx = PRESS_DB;
                    end else begin
                        col_nx = col + 2'd1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            PRESS_DB:
                if (rlow != cand) begin
                    state_nx = SCAN;
                    cnt_nx   = '0;
                    col_nx   = col + 2'd1;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    val_nx   = {cand, 4'b1000 >> col};
                    valid_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            HELD:
                if (!held_row) begin
                    state_nx = REL_DB;
                    cnt_nx   = '0;
                end
            REL_DB:
                if (held_row) begin
                    state_nx = HELD;
                end else if (cnt == DB_LAST) begin
                    state_nx = SCAN;
                    cnt_nx   = '0;
                    col_nx   = col + 2'd1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            default: state_nx = SCAN;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep, rep_nx;

    // Repeat count advances only while held, pauses across a release bounce, clears otherwise.
    always_comb begin
        rep_nx   = (state == HELD || state == REL_DB) ? rep : '0;
        rep_fire = 1'b0;
        if (state == HELD && held_row) begin
            rep_fire = (rep == REP_LAST);
            rep_nx   = rep_fire ? '0 : rep + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rep <= '0;
        else          rep <= rep_nx;
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_meta     <= 4'hF;
            rs         <= 4'hF;
            state      <= SCAN;
            cnt        <= '0;
            col        <= '0;
            cand       <= '0;
            keypad_val <= '0;
            key_valid  <= 1'b0;
        end else begin
            r_meta     <= rows;
            rs         <= r_meta;
            state      <= state_nx;
            cnt        <= cnt_nx;
            col        <= col_nx;
            cand       <= cand_nx;
            keypad_val <= val_nx;
            key_valid  <= valid_nx | rep_fire;
        end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a key-matrix model driving rows from cols.
// Build with KEYPAD_AUTOREPEAT_EN defined to also expect the repeat pulses.
module tb_keypad_scanner;
    localparam logic [15:0] K1 = 16'h0001;   // r0 c0
    localparam logic [15:0] K4 = 16'h0010;   // r1 c0
    localparam logic [15:0] K5 = 16'h0020;   // r1 c1
    localparam logic [15:0] KC = 16'h0008;   // r0 c3
    localparam logic [15:0] K9 = 16'h0400;   // r2 c2
    localparam logic [15:0] K0 = 16'h2000;   // r3 c1
    localparam logic [15:0] KF = 16'h8000;   // r3 c3

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  cols;
        logic        valid;
        logic [7:0]  val;
    } vec_t;

    logic        clk, reset_n;
    logic [3:0]  rows, cols;
    logic [7:0]  keypad_val;
    logic        key_valid;
    logic [15:0] keys;
    int          checks, errors;
    vec_t        vecs[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .rows(rows), .cols(cols),
        .keypad_val(keypad_val), .key_valid(key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] k, input logic [3:0] c, input logic v, input logic [7:0] d, input int n);
        vec_t e;
        e.keys = k; e.cols = c; e.valid = v; e.val = d;
        for (int i = 0; i < n; i++) vecs.push_back(e);
    endtask

    task automatic run_no_pulse(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(name, {7'd0, key_valid}, 8'd0);
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int found;
        found = 0;
        for (int i = 0; i < limit && found == 0; i++) begin
            tick();
            if (key_valid) found = 1;
        end
        check({name, " pulse seen"}, 8'(found), 8'd1);
    endtask

    task automatic wait_leave(input string name, input logic [3:0] c, input int limit);
        int moved;
        moved = 0;
        for (int i = 0; i < limit && moved == 0; i++) begin
            tick();
            if (cols != c) moved = 1;
        end
        check({name, " scan resumed"}, 8'(moved), 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        // reset scan, then a clean "5" press and release, one vector per clock
        add(16'h0, 4'b1110, 1'b0, 8'h00, 3);
        add(16'h0, 4'b1101, 1'b0, 8'h00, 4);
        add(16'h0, 4'b1011, 1'b0, 8'h00, 4);
        add(16'h0, 4'b0111, 1'b0, 8'h00, 4);
        add(16'h0, 4'b1110, 1'b0, 8'h00, 4);
        add(16'h0, 4'b1101, 1'b0, 8'h00, 1);
        add(K5,    4'b1101, 1'b0, 8'h00, 11);
        add(K5,    4'b1101, 1'b1, 8'h24, 1);
        add(K5,    4'b1101, 1'b0, 8'h24, 4);
        add(16'h0, 4'b1101, 1'b0, 8'h24, 10);
        add(16'h0, 4'b1011, 1'b0, 8'h24, 2);

        reset_n = 1'b0;
        keys = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            keys = 16'($urandom);
            check("reset cols", {4'd0, cols}, 8'h0E);
            check("reset val", keypad_val, 8'h00);
            check("reset valid", {7'd0, key_valid}, 8'd0);
        end
        keys = 16'h0;
        tick();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            keys = vecs[i].keys;
            tick();
            check($sformatf("vec%0d cols", i), {4'd0, cols}, {4'd0, vecs[i].cols});
            check($sformatf("vec%0d valid", i), {7'd0, key_valid}, {7'd0, vecs[i].valid});
            check($sformatf("vec%0d val", i), keypad_val, vecs[i].val);
        end

        // bouncing "C": 3-cycle toggles never survive the debounce
        for (int p = 0; p < 8; p++) begin
            keys = p[0] ? 16'h0 : KC;
            run_no_pulse("bounce C", 3);
        end
        keys = KC;
        wait_valid("C", 60);
        check("C val", keypad_val, 8'h11);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("C single pulse", {7'd0, key_valid}, 8'd0);
            check("C cols frozen", {4'd0, cols}, 8'h07);
        end
        keys = 16'h0;
        wait_leave("C", 4'b0111, 30);

        // two keys in one column are never accepted
        keys = K1 | K4;
        run_no_pulse("two keys col0", 40);
        check("two keys val kept", keypad_val, 8'h11);
        keys = K1;
        wait_valid("1", 60);
        check("1 val", keypad_val, 8'h18);
        keys = K1 | K9;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("9 while 1 held valid", {7'd0, key_valid}, 8'd0);
            check("9 while 1 held cols", {4'd0, cols}, 8'h0E);
        end
        check("9 while 1 held val", keypad_val, 8'h18);
        keys = 16'h0;
        wait_leave("1", 4'b1110, 30);

        // short release glitch on "0" returns to HELD without a new pulse
        keys = K0;
        wait_valid("0", 60);
        check("0 val", keypad_val, 8'h84);
        run_no_pulse("0 held", 2);
        keys = 16'h0;
        run_no_pulse("0 glitch", 4);
        keys = K0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("0 after glitch valid", {7'd0, key_valid}, 8'd0);
            check("0 after glitch cols", {4'd0, cols}, 8'h0D);
        end
        keys = 16'h0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("0 release debounce cols", {4'd0, cols}, 8'h0D);
        end
        tick();
        check("0 release done cols", {4'd0, cols}, 8'h0B);

        // long hold of "F": repeats only when autorepeat is built in
        keys = KF;
        wait_valid("F", 60);
        check("F val", keypad_val, 8'h81);
        for (int k = 1; k <= 60; k++) begin
            logic exp_v;
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_v = (k % 16 == 0);
`else
            exp_v = 1'b0;
`endif
            tick();
            check($sformatf("F hold %0d valid", k), {7'd0, key_valid}, {7'd0, exp_v});
            check($sformatf("F hold %0d val", k), keypad_val, 8'h81);
        end

        // asynchronous reset while held
        #3 reset_n = 1'b0;
        #1;
        check("async reset cols", {4'd0, cols}, 8'h0E);
        check("async reset val", keypad_val, 8'h00);
        check("async reset valid", {7'd0, key_valid}, 8'd0);
        keys = 16'h0;
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("restart cols %0d", i), {4'd0, cols}, (i < 4) ? 8'h0E : 8'h0D);
            check("restart valid", {7'd0, key_valid}, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
